// File: rtl/mnist_frame_buffer_pkg.sv
// Shared types and default geometry for the MNIST frame buffer.
package mnist_pkg;

   localparam int IMG_PIXELS_DEF = 784;
   localparam int ADDR_W_DEF     = 10;
   localparam int PIXEL_W_DEF    = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/mnist_frame_buffer_if.sv
// Pixel write / frame-commit / result handshake bundle of the frame buffer.
interface mnist_frame_buffer_if #(
   parameter int ADDR_W  = mnist_pkg::ADDR_W_DEF,
   parameter int PIXEL_W = mnist_pkg::PIXEL_W_DEF
) ();

   logic               wr_valid;
   logic [ADDR_W-1:0]  wr_addr;
   logic [PIXEL_W-1:0] wr_data;
   logic               wr_ready;
   logic               frame_done;
   logic               res_valid;
   logic               res_ready;
   logic [3:0]         digit;

   modport master (
      output wr_valid, wr_addr, wr_data, frame_done, res_ready,
      input  wr_ready, res_valid, digit
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, frame_done, res_ready,
      output wr_ready, res_valid, digit
   );

endinterface

// File: rtl/mnist_frame_buffer_classifier.sv
// Reference classifier: digit = (number of set pixels) mod 10, delivered
// through LATENCY register stages after the image is stable.
module mnist_classifier #(
   parameter int IMG_PIXELS = 784,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [IMG_PIXELS-1:0] image,
   output logic [3:0]            digit
);

   localparam int CW = $clog2(IMG_PIXELS + 1);
   localparam logic [CW-1:0] TEN = CW'(10);

   logic [CW-1:0] count;
   logic [3:0]    raw;
   logic [3:0]    stage [LATENCY];

   always_comb begin
      count = '0;
      for (int i = 0; i < IMG_PIXELS; i++) begin
         count = count + CW'(image[i]);
      end
      raw = 4'(count % TEN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LATENCY; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= raw;
         for (int i = 1; i < LATENCY; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign digit = stage[LATENCY-1];

endmodule

// File: rtl/mnist_frame_buffer.sv
// Double-banked binarised frame buffer feeding the digit classifier.
//
//   state | meaning
//   IDLE  | no classification running, waiting for a frame commit
//   RUN   | compute bank frozen, waiting for classifier to settle
//   HOLD  | digit/res_valid presented, waiting for res_ready
module mnist_frame_buffer
   import mnist_pkg::*;
#(
   parameter int IMG_PIXELS  = IMG_PIXELS_DEF,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int PIXEL_W     = PIXEL_W_DEF,
   parameter int THRESHOLD   = 128,
   parameter int CLS_LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mnist_frame_buffer_if.slave  bus,
   output logic                 busy,
   output logic                 err_addr,
   output logic                 err_overrun
);

   localparam int CNT_W = $clog2(CLS_LATENCY + 1);

   logic [IMG_PIXELS-1:0] bank_q [2];
   logic                  sel;
   state_t                state;
   logic                  pending;
   logic [CNT_W-1:0]      cnt;
   logic [3:0]            digit_q;
   logic                  res_valid_q;
   logic                  err_addr_q;
   logic                  err_overrun_q;

   logic                  wr_accept;
   logic                  addr_ok;
   logic                  pix_bit;
   logic                  commit;
   logic [3:0]            cls_digit;
   logic [IMG_PIXELS-1:0] load_bank;
   logic [IMG_PIXELS-1:0] compute_bank;

   assign load_bank    = bank_q[sel];
   assign compute_bank = bank_q[~sel];

   always_comb begin
      wr_accept = bus.wr_valid && !pending;
      addr_ok   = 32'(bus.wr_addr) < IMG_PIXELS;
      pix_bit   = 32'(bus.wr_data) >= THRESHOLD;
      // A HOLD handshake with a frame waiting goes straight back to RUN.
      commit    = ((state == IDLE) && (bus.frame_done || pending)) ||
                  ((state == HOLD) && bus.res_ready && (bus.frame_done || pending));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_q[0]     <= '0;
         bank_q[1]     <= '0;
         sel           <= 1'b0;
         state         <= IDLE;
         pending       <= 1'b0;
         cnt           <= '0;
         digit_q       <= '0;
         res_valid_q   <= 1'b0;
         err_addr_q    <= 1'b0;
         err_overrun_q <= 1'b0;
      end else begin
         if (wr_accept) begin
            if (addr_ok) begin
               bank_q[sel][bus.wr_addr] <= pix_bit;
            end else begin
               err_addr_q <= 1'b1;
            end
         end

         if (bus.frame_done && pending) begin
            err_overrun_q <= 1'b1;
         end

         if (commit) begin
            // Same-cycle write lands in bank_q[sel], which becomes the compute bank.
            sel           <= ~sel;
            bank_q[~sel]  <= '0;
            cnt           <= '0;
            pending       <= 1'b0;
            res_valid_q   <= 1'b0;
            state         <= RUN;
         end else begin
            case (state)
               RUN: begin
                  if (bus.frame_done) pending <= 1'b1;
                  if (cnt == CNT_W'(CLS_LATENCY)) begin
                     digit_q     <= cls_digit;
                     res_valid_q <= 1'b1;
                     state       <= HOLD;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               HOLD: begin
                  if (bus.frame_done) pending <= 1'b1;
                  if (bus.res_ready) begin
                     res_valid_q <= 1'b0;
                     state       <= IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   mnist_classifier #(
      .IMG_PIXELS (IMG_PIXELS),
      .LATENCY    (CLS_LATENCY)
   ) u_classifier (
      .clk   (clk),
      .rst_n (rst_n),
      .image (compute_bank),
      .digit (cls_digit)
   );

   assign bus.wr_ready  = !pending;
   assign bus.res_valid = res_valid_q;
   assign bus.digit     = digit_q;
   assign busy          = (state != IDLE) || pending;
   assign err_addr      = err_addr_q;
   assign err_overrun   = err_overrun_q;

endmodule

// File: tb/tb_mnist_frame_buffer.sv
// Scoreboard bench for mnist_frame_buffer: directed frames, queued expected digits.
module tb_mnist_frame_buffer;

   localparam int LAT = 2;

   logic clk;
   logic rst_n;
   logic busy;
   logic err_addr;
   logic err_overrun;

   int checks   = 0;
   int failures = 0;
   int exp_q [$];

   mnist_frame_buffer_if #(.ADDR_W(10), .PIXEL_W(8)) bus ();

   mnist_frame_buffer #(
      .IMG_PIXELS  (784),
      .ADDR_W      (10),
      .PIXEL_W     (8),
      .THRESHOLD   (128),
      .CLS_LATENCY (LAT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .busy        (busy),
      .err_addr    (err_addr),
      .err_overrun (err_overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic drive(input bit v, input int a, input int d, input bit fd);
      bus.wr_valid   = v;
      bus.wr_addr    = 10'(a);
      bus.wr_data    = 8'(d);
      bus.frame_done = fd;
      @(posedge clk);
      #1;
      bus.wr_valid   = 1'b0;
      bus.frame_done = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk);
         #1;
         if (!busy && !bus.res_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check("idle_reached", int'(ok), 1);
   endtask

   task automatic wait_res_valid();
      bit ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk);
         #1;
         if (bus.res_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check("res_valid_reached", int'(ok), 1);
   endtask

   // Digit-7 glyph: two-row top bar plus a two-pixel-wide diagonal stroke.
   // Set pixels: 15 + 16 + 18*2 = 67, so the reference classifier reports 7.
   function automatic bit seven_px(input int r, input int c);
      int cc;
      if (r == 4 && c >= 6 && c <= 20) return 1'b1;
      if (r == 5 && c >= 6 && c <= 21) return 1'b1;
      if (r >= 6 && r <= 23) begin
         cc = 21 - ((r - 6) / 2);
         if (c == cc || c == cc - 1) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Monitor: pops one expected digit per accepted result.
   initial begin
      bit         prev_rv = 1'b0;
      logic [3:0] prev_digit = '0;
      int         e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_rv = 1'b0;
         end else begin
            if (bus.res_valid && prev_rv) check("digit_stable", int'(bus.digit), int'(prev_digit));
            if (bus.res_valid && bus.res_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_result actual=%0d required=no_result", bus.digit);
               end else begin
                  e = exp_q.pop_front();
                  check("digit", int'(bus.digit), e);
               end
            end
            prev_rv    = bus.res_valid;
            prev_digit = bus.digit;
         end
      end
   end

   initial begin
      logic [783:0] exp_bank;
      int lat;

      rst_n          = 1'b0;
      bus.wr_valid   = 1'b0;
      bus.wr_addr    = '0;
      bus.wr_data    = '0;
      bus.frame_done = 1'b0;
      bus.res_ready  = 1'b1;
      #12;
      check("rst_res_valid", int'(bus.res_valid), 0);
      check("rst_wr_ready",  int'(bus.wr_ready), 1);
      check("rst_busy",      int'(busy), 0);
      check("rst_digit",     int'(bus.digit), 0);
      check("rst_errs",      int'({err_addr, err_overrun}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Digit-7 frame and result latency
      for (int r = 0; r < 28; r++)
         for (int c = 0; c < 28; c++)
            drive(1'b1, r * 28 + c, seven_px(r, c) ? 255 : 0, 1'b0);
      exp_q.push_back(7);
      drive(1'b0, 0, 0, 1'b1);
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
         if (bus.res_valid) begin
            lat = k;
            break;
         end
         @(posedge clk);
         #1;
      end
      check("latency", lat, LAT + 2);
      wait_idle();

      // Threshold boundary at addr 5
      exp_q.push_back(0);
      drive(1'b1, 5, 127, 1'b1);
      check("bit5_127", int'(dut.compute_bank[5]), 0);
      wait_idle();
      exp_q.push_back(1);
      drive(1'b1, 5, 128, 1'b1);
      check("bit5_128", int'(dut.compute_bank[5]), 1);
      wait_idle();

      // Out-of-range address
      drive(1'b1, 800, 255, 1'b0);
      exp_bank    = '0;
      exp_bank[5] = 1'b1;
      check("err_addr_set",    int'(err_addr), 1);
      check("wr_ready_oob",    int'(bus.wr_ready), 1);
      check("load_untouched",  int'(dut.load_bank == 784'(0)), 1);
      check("compute_untouched", int'(dut.compute_bank == exp_bank), 1);

      // Back-pressured result with pending frame and overrun
      bus.res_ready = 1'b0;
      for (int a = 0; a < 3; a++) drive(1'b1, a, 255, 1'b0);
      exp_q.push_back(3);
      drive(1'b0, 0, 0, 1'b1);
      wait_res_valid();
      for (int a = 10; a < 14; a++) drive(1'b1, a, 200, 1'b0);
      exp_q.push_back(4);
      drive(1'b0, 0, 0, 1'b1);
      check("pend_wr_ready", int'(bus.wr_ready), 0);
      check("pend_busy",     int'(busy), 1);
      check("pre_overrun",   int'(err_overrun), 0);
      drive(1'b0, 0, 0, 1'b1);
      check("err_overrun_set", int'(err_overrun), 1);
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1;
      check("handoff_res_valid", int'(bus.res_valid), 0);
      check("handoff_busy",      int'(busy), 1);
      check("handoff_wr_ready",  int'(bus.wr_ready), 1);
      check("frame_b_bit10",     int'(dut.compute_bank[10]), 1);
      check("frame_b_bit0",      int'(dut.compute_bank[0]), 0);
      wait_idle();

      // Write coincident with frame_done
      drive(1'b1, 1, 255, 1'b0);
      exp_q.push_back(2);
      drive(1'b1, 0, 255, 1'b1);
      check("same_cycle_bit0", int'(dut.compute_bank[0]), 1);
      check("same_cycle_bit1", int'(dut.compute_bank[1]), 1);
      check("load_bit0_clear", int'(dut.load_bank[0]), 0);
      wait_idle();

      // Reset during RUN
      drive(1'b1, 3, 255, 1'b0);
      drive(1'b0, 0, 0, 1'b1);
      check("run_busy", int'(busy), 1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_res_valid", int'(bus.res_valid), 0);
      check("mid_rst_busy",      int'(busy), 0);
      check("mid_rst_wr_ready",  int'(bus.wr_ready), 1);
      check("mid_rst_errs",      int'({err_addr, err_overrun}), 0);
      check("mid_rst_digit",     int'(bus.digit), 0);
      check("mid_rst_compute",   int'(dut.compute_bank == 784'(0)), 1);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 7, 255, 1'b0);
      check("first_write_after_rst", int'(dut.load_bank[7]), 1);
      repeat (12) @(posedge clk);
      #1;
      check("post_rst_busy", int'(busy), 0);
      check("queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
